// File: rtl/rv32i_types.sv
// Shared RV32I control encodings and the MEM-stage data-port FSM state type.
package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HELD
  } dport_state_t;

  // funct3[1:0] encodes access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half/word of a cache read word and sign/zero-extends it.
module load_align
  import rv32i_types::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel = data_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? data_i[31:16] : data_i[15:0];
    case (load_funct3_t'(funct3_i))
      lb:      rdata_o = 32'(byte_sel);
      lbu:     rdata_o = {24'h0, byte_sel};
      lh:      rdata_o = 32'(half_sel);
      lhu:     rdata_o = {16'h0, half_sel};
      default: rdata_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_dport_ctrl.sv
// MEM-stage data-port controller: issues cache loads/stores, aligns load data,
// stalls the pipeline while waiting, and holds a response across external stalls.
module mem_dport_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic [2:0]       funct3_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  input  logic             ext_stall_i,
  input  logic             data_resp,
  input  logic [31:0]      data_rdata,
  output logic             data_read,
  output logic             data_write,
  output logic [3:0]       data_mbe,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  output logic [31:0]      rdata_o,
  output logic             stall_o,
  output logic             misaligned_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  dport_state_t     state_q, state_d;
  logic [31:0]      hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        access, req, issue;
  logic [1:0]  off;
  logic [31:0] aligned;
  logic [3:0]  store_mbe;

  assign off          = addr_i[1:0];
  assign access       = valid_i & (mem_read_i | mem_write_i);
  assign misaligned_o = access & is_misaligned(funct3_i, off);
  assign req          = access & ~misaligned_o;
  assign data_addr    = {addr_i[31:2], 2'b00};
  assign stall_cnt_o  = cnt_q;

  load_align u_load_align (
    .data_i   (data_rdata),
    .off_i    (off),
    .funct3_i (funct3_i),
    .rdata_o  (aligned)
  );

  // Request side: no bubble, and nothing leaves the port during reset or HELD.
  always_comb begin
    issue      = req & (state_q != HELD) & ~rst;
    data_read  = issue & mem_read_i;
    data_write = issue & mem_write_i;
    stall_o    = issue & ~data_resp;

    case (store_funct3_t'(funct3_i))
      sb: begin
        store_mbe  = 4'b0001 << off;
        data_wdata = {4{wdata_i[7:0]}};
      end
      sh: begin
        store_mbe  = 4'b0011 << off;
        data_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        store_mbe  = 4'hF;
        data_wdata = wdata_i;
      end
    endcase

    data_mbe = 4'h0;
    if (data_read)       data_mbe = 4'hF;
    else if (data_write) data_mbe = store_mbe;

    rdata_o = 32'h0;
    if (state_q == HELD)        rdata_o = hold_q;
    else if (req & mem_read_i)  rdata_o = aligned;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      HELD: if (!ext_stall_i) state_d = IDLE;
      default: begin
        if (req && data_resp) begin
          if (ext_stall_i) begin
            state_d = HELD;
            hold_d  = mem_read_i ? aligned : 32'h0;
          end else begin
            state_d = IDLE;
          end
        end else if (req) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    if (stall_o && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
